// File: rtl/uart_rx_framer.sv
// UART receive framer: detects a start bit on the synchronized line, samples
// start/data/stop on rising edges of an externally generated baud pulse, and
// hands completed bytes to a consumer with a valid/ack handshake.
module uart_rx_framer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 pulse_rx,
    output logic                 rx_val,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ack,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 timeout_err
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic                 rxd_meta_q, rxd_s_q, rxd_s_dly_q;
    logic                 pulse_q;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 rx_val_q, rx_val_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 to_q, to_d;
    logic                 pulse_edge;
    logic                 line_fall;

    assign pulse_edge = pulse_rx & ~pulse_q;
    // Falling edge needs a high-then-low pair, so a held-low line never restarts.
    assign line_fall  = rxd_s_dly_q & ~rxd_s_q;

    // Line synchronizer, its one-cycle delay, and pulse edge history.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_s_dly_q <= 1'b1;
            pulse_q     <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            rxd_s_dly_q <= rxd_s_q;
            pulse_q     <= pulse_rx;
        end
    end

    // Framer state and registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            rx_val_q  <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            rx_val_q  <= rx_val_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            to_q      <= to_d;
        end
    end

    // Next-state, shift/load, handshake and error pulse logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        to_d      = 1'b0;

        if (valid_q && rx_data_ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                tmo_cnt_d = '0;
                if (line_fall) begin
                    state_d   = StStart;
                    bit_cnt_d = '0;
                end
            end
            StStart: begin
                // A high line at mid-start-bit is a glitch: drop it silently.
                if (pulse_edge) begin
                    state_d = rxd_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (pulse_edge) begin
                    shreg_d   = (shreg_q >> 1) | (DATA_BITS'(rxd_s_q) << (DATA_BITS - 1));
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                    if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (pulse_edge) begin
                    // Byte is delivered even with a bad stop bit; ack in the
                    // same cycle counts as consumption, so no overrun.
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    ov_d    = valid_q & ~rx_data_ack;
                    fe_d    = ~rxd_s_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog on missing baud pulses while a frame is in progress.
        if (state_q != StIdle) begin
            if (pulse_edge) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                state_d   = StIdle;
                to_d      = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
        end

        rx_val_d = (state_d != StIdle);
    end

    assign rx_val        = rx_val_q;
    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign frame_err     = fe_q;
    assign overrun_err   = ov_q;
    assign timeout_err   = to_q;

endmodule
